vending_ctrl_mp: RTL and testbench
==================================

Name: vending_ctrl_mp

Overview:
Parametrised multi-product vending controller that supersedes the fixed three-product vending core. It accepts commands over a valid/ready interface, tracks credit, per-product price and stock, and vends. Change is dispensed greedily as one coin per handshake beat rather than in a single cycle. It sits between the command/coin front end and the dispenser/coin-return actuators.

Parameters:
N_PROD, 4, number of products (2..16); PROD_W = $clog2(N_PROD) is derived.
MONEY_W, 11, width of credit and price registers, in grosz.
QTY_W, 3, width of per-product stock counters.
DEFAULT_PRICE, 250, reset price of every product.
DEFAULT_QTY, 2, reset stock of every product.
TIMEOUT_CYC, 1000000, idle cycles before auto-refund (optional feature only).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  controller accepts a command; high only in IDLE and low while rst is high.
cmd_op  in  3  0 COIN, 1 BUY, 2 SET_PRICE, 3 SET_QTY, 4 REFUND, 5-7 reserved.
cmd_prod  in  PROD_W  product index for BUY, SET_PRICE and SET_QTY.
cmd_arg  in  MONEY_W  COIN: code in [2:0]; SET_PRICE: price; SET_QTY: qty in [QTY_W-1:0].
vend_valid  out  1  one-cycle pulse; product released.
vend_prod  out  PROD_W  index of the released product; valid with vend_valid.
coin_valid  out  1  change coin presented.
coin_code  out  3  coin code, same encoding as COIN.
coin_ready  in  1  coin-return mechanism took the coin.
err_valid  out  1  one-cycle pulse; command rejected.
err_code  out  3  1 bad coin, 2 overflow, 3 bad product, 4 no credit, 5 out of stock.
credit  out  MONEY_W  current credit.

Behaviour:
- Reset, synchronous: state IDLE; credit 0; all prices DEFAULT_PRICE; all stock DEFAULT_QTY; vend_valid, coin_valid, err_valid 0; vend_prod, coin_code, err_code 0.
- Coin map: 1→1, 2→2, 3→5, 4→10, 5→20, 6→50. Codes 0 and 7 are invalid.
- A command is accepted when cmd_valid and cmd_ready are high at a rising edge. All effects become visible in the next cycle.
- States:
  - IDLE: cmd_ready=1.
  - VEND: one cycle. vend_valid=1. Next state is CHANGE if credit>0, else IDLE.
  - CHANGE: cmd_ready=0.
- Command handling:
  - COIN: valid code and credit+value ≤ 2^MONEY_W−1 → credit += value. Invalid code → err 1. Overflow → err 2. On any error, credit is unchanged.
  - BUY: checks are applied in this priority order:
    1. cmd_prod ≥ N_PROD → err 3.
    2. credit < price → err 4.
    3. stock = 0 → err 5.
    If all pass: credit −= price, stock −= 1, go to VEND.
  - SET_PRICE: price[cmd_prod] <= cmd_arg. Bad index → err 3.
  - SET_QTY: stock[cmd_prod] <= cmd_arg[QTY_W-1:0]. Bad index → err 3.
  - REFUND: credit>0 → CHANGE; credit=0 → no action, no error.
  - Reserved ops: accepted, no effect.
- CHANGE:
  - coin_valid=1.
  - coin_code is the largest coin ≤ credit.
  - On coin_ready, credit decreases by that coin's value. If the new credit is 0, go to IDLE the next cycle; otherwise present the next coin.
  - coin_code is stable while coin_valid=1 and coin_ready=0.
  - coin_valid drops in the cycle after the last beat.
- Stock never wraps below 0, because BUY is rejected at 0. A price of 0 is legal and vends with no credit deduction.
- SET_QTY and SET_PRICE on a product do not affect a vend already in progress. No command is accepted outside IDLE.
- rst asserted in any state aborts the operation:
  - Pending change is lost.
  - vend_valid and coin_valid deassert in the next cycle.

Optional Feature:
Macro VENDING_TIMEOUT_EN.
- Defined: a counter increments each cycle in IDLE while credit>0 and no command is accepted. It clears on any accepted command or when credit=0. On reaching TIMEOUT_CYC−1 the controller enters CHANGE exactly as for REFUND.
- Undefined: no counter; credit is held indefinitely.

Test Plan:
- Price 250 for product 0. Insert codes 6,6,6,6,6,4 (260), then BUY 0 → vend_valid with vend_prod=0 one cycle after accept; one coin beat code 4 (10); credit 0; stock 2→1.
- BUY 1 with credit 30, price 250 → err 4; credit stays 30; no vend. Then REFUND → coin beats 20 then 10, in that order.
- SET_QTY product 2 to 0, insert 300, BUY 2 → err 5. BUY with cmd_prod=N_PROD → err 3.
- Change of 88 with coin_ready held low for 3 cycles on each beat → sequence 50, 20, 10, 5, 2, 1 with coin_code stable while stalled; cmd_ready=0 throughout.
- Credit 2040, COIN code 6 → err 2, credit still 2040. COIN code 7 → err 1.
- Assert rst mid-CHANGE → next cycle coin_valid=0, credit=0, prices and stock at defaults. With VENDING_TIMEOUT_EN and TIMEOUT_CYC=16, credit 5 idle for 16 cycles → auto change beat code 3.

Source files
------------

// File: rtl/vending_ctrl_mp.sv
// Multi-product vending controller: credit, per-product price/stock, vend, and greedy one-coin-per-beat change.
// Optional idle auto-refund is enabled by defining VENDING_TIMEOUT_EN.
module vending_ctrl_mp #(
   parameter int unsigned N_PROD        = 4,
   parameter int unsigned MONEY_W       = 11,
   parameter int unsigned QTY_W         = 3,
   parameter int unsigned DEFAULT_PRICE = 250,
   parameter int unsigned DEFAULT_QTY   = 2,
`ifdef VENDING_TIMEOUT_EN
   parameter int unsigned TIMEOUT_CYC   = 1000000,
`endif
   localparam int unsigned PROD_W       = $clog2(N_PROD)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [2:0]         cmd_op,
   input  logic [PROD_W-1:0]  cmd_prod,
   input  logic [MONEY_W-1:0] cmd_arg,
   output logic               vend_valid,
   output logic [PROD_W-1:0]  vend_prod,
   output logic               coin_valid,
   output logic [2:0]         coin_code,
   input  logic               coin_ready,
   output logic               err_valid,
   output logic [2:0]         err_code,
   output logic [MONEY_W-1:0] credit
);

   localparam int unsigned PI_W = PROD_W + 1;

   localparam logic [2:0] OP_COIN      = 3'd0;
   localparam logic [2:0] OP_BUY       = 3'd1;
   localparam logic [2:0] OP_SET_PRICE = 3'd2;
   localparam logic [2:0] OP_SET_QTY   = 3'd3;
   localparam logic [2:0] OP_REFUND    = 3'd4;

   localparam logic [2:0] ERR_BAD_COIN  = 3'd1;
   localparam logic [2:0] ERR_OVERFLOW  = 3'd2;
   localparam logic [2:0] ERR_BAD_PROD  = 3'd3;
   localparam logic [2:0] ERR_NO_CREDIT = 3'd4;
   localparam logic [2:0] ERR_NO_STOCK  = 3'd5;

   typedef enum logic [1:0] {S_IDLE, S_VEND, S_CHANGE} state_t;

   state_t             state;
   logic [MONEY_W-1:0] price [N_PROD];
   logic [QTY_W-1:0]   qty   [N_PROD];

   logic               accept;
   logic               prod_ok;
   logic               coin_ok;
   logic [MONEY_W:0]   coin_sum;
   logic [MONEY_W-1:0] sel_price;
   logic [QTY_W-1:0]   sel_qty;
   logic [MONEY_W-1:0] credit_less;
`ifdef VENDING_TIMEOUT_EN
   logic [31:0]        tmo_cnt;
`endif

   function automatic logic [MONEY_W-1:0] coin_value(input logic [2:0] code);
      case (code)
         3'd1:    return MONEY_W'(1);
         3'd2:    return MONEY_W'(2);
         3'd3:    return MONEY_W'(5);
         3'd4:    return MONEY_W'(10);
         3'd5:    return MONEY_W'(20);
         3'd6:    return MONEY_W'(50);
         default: return '0;
      endcase
   endfunction

   // Greedy change: largest coin not exceeding the remaining amount.
   function automatic logic [2:0] best_coin(input logic [MONEY_W-1:0] amt);
      if (amt >= MONEY_W'(50))      return 3'd6;
      else if (amt >= MONEY_W'(20)) return 3'd5;
      else if (amt >= MONEY_W'(10)) return 3'd4;
      else if (amt >= MONEY_W'(5))  return 3'd3;
      else if (amt >= MONEY_W'(2))  return 3'd2;
      else if (amt >= MONEY_W'(1))  return 3'd1;
      else                          return 3'd0;
   endfunction

   assign cmd_ready   = (state == S_IDLE) && !rst;
   assign accept      = cmd_valid && cmd_ready;
   assign prod_ok     = {1'b0, cmd_prod} < PI_W'(N_PROD);
   assign coin_ok     = (cmd_arg[2:0] != 3'd0) && (cmd_arg[2:0] != 3'd7);
   assign coin_sum    = {1'b0, credit} + {1'b0, coin_value(cmd_arg[2:0])};
   assign sel_price   = price[cmd_prod];
   assign sel_qty     = qty[cmd_prod];
   assign credit_less = credit - coin_value(coin_code);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         credit     <= '0;
         vend_valid <= 1'b0;
         vend_prod  <= '0;
         coin_valid <= 1'b0;
         coin_code  <= '0;
         err_valid  <= 1'b0;
         err_code   <= '0;
         for (int i = 0; i < N_PROD; i++) begin
            price[i] <= MONEY_W'(DEFAULT_PRICE);
            qty[i]   <= QTY_W'(DEFAULT_QTY);
         end
`ifdef VENDING_TIMEOUT_EN
         tmo_cnt    <= '0;
`endif
      end else begin
         vend_valid <= 1'b0;
         err_valid  <= 1'b0;
`ifdef VENDING_TIMEOUT_EN
         tmo_cnt    <= '0;
`endif
         case (state)
            S_IDLE: begin
               if (accept) begin
                  case (cmd_op)
                     OP_COIN: begin
                        if (!coin_ok) begin
                           err_valid <= 1'b1;
                           err_code  <= ERR_BAD_COIN;
                        end else if (coin_sum[MONEY_W]) begin
                           err_valid <= 1'b1;
                           err_code  <= ERR_OVERFLOW;
                        end else begin
                           credit <= coin_sum[MONEY_W-1:0];
                        end
                     end
                     OP_BUY: begin
                        if (!prod_ok) begin
                           err_valid <= 1'b1;
                           err_code  <= ERR_BAD_PROD;
                        end else if (credit < sel_price) begin
                           err_valid <= 1'b1;
                           err_code  <= ERR_NO_CREDIT;
                        end else if (sel_qty == '0) begin
                           err_valid <= 1'b1;
                           err_code  <= ERR_NO_STOCK;
                        end else begin
                           credit         <= credit - sel_price;
                           qty[cmd_prod]  <= sel_qty - QTY_W'(1);
                           vend_valid     <= 1'b1;
                           vend_prod      <= cmd_prod;
                           state          <= S_VEND;
                        end
                     end
                     OP_SET_PRICE: begin
                        if (prod_ok) begin
                           price[cmd_prod] <= cmd_arg;
                        end else begin
                           err_valid <= 1'b1;
                           err_code  <= ERR_BAD_PROD;
                        end
                     end
                     OP_SET_QTY: begin
                        if (prod_ok) begin
                           qty[cmd_prod] <= cmd_arg[QTY_W-1:0];
                        end else begin
                           err_valid <= 1'b1;
                           err_code  <= ERR_BAD_PROD;
                        end
                     end
                     OP_REFUND: begin
                        if (credit != '0) begin
                           state      <= S_CHANGE;
                           coin_valid <= 1'b1;
                           coin_code  <= best_coin(credit);
                        end
                     end
                     default: ;
                  endcase
               end
`ifdef VENDING_TIMEOUT_EN
               // Idle credit with no traffic is refunded after TIMEOUT_CYC cycles.
               else if (credit != '0) begin
                  if (tmo_cnt == 32'(TIMEOUT_CYC - 1)) begin
                     state      <= S_CHANGE;
                     coin_valid <= 1'b1;
                     coin_code  <= best_coin(credit);
                  end else begin
                     tmo_cnt <= tmo_cnt + 32'd1;
                  end
               end
`endif
            end
            S_VEND: begin
               if (credit != '0) begin
                  state      <= S_CHANGE;
                  coin_valid <= 1'b1;
                  coin_code  <= best_coin(credit);
               end else begin
                  state <= S_IDLE;
               end
            end
            S_CHANGE: begin
               // coin_code only moves on a completed beat, so it is stable while stalled.
               if (coin_ready) begin
                  credit <= credit_less;
                  if (credit_less == '0) begin
                     state      <= S_IDLE;
                     coin_valid <= 1'b0;
                  end else begin
                     coin_code <= best_coin(credit_less);
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vending_ctrl_mp.sv
// Directed bench for vending_ctrl_mp; N_PROD=5 so an out-of-range product index is reachable.
module tb_vending_ctrl_mp;

   localparam int unsigned N_PROD  = 5;
   localparam int unsigned PROD_W  = 3;
   localparam int unsigned MONEY_W = 11;

   localparam int OP_COIN = 0, OP_BUY = 1, OP_SET_PRICE = 2, OP_SET_QTY = 3, OP_REFUND = 4;

   logic               clk;
   logic               rst;
   logic               cmd_valid;
   logic               cmd_ready;
   logic [2:0]         cmd_op;
   logic [PROD_W-1:0]  cmd_prod;
   logic [MONEY_W-1:0] cmd_arg;
   logic               vend_valid;
   logic [PROD_W-1:0]  vend_prod;
   logic               coin_valid;
   logic [2:0]         coin_code;
   logic               coin_ready;
   logic               err_valid;
   logic [2:0]         err_code;
   logic [MONEY_W-1:0] credit;

   int vectors = 0;
   int miscompares = 0;
   int exp_q[$];

   vending_ctrl_mp #(
      .N_PROD(N_PROD)
`ifdef VENDING_TIMEOUT_EN
      , .TIMEOUT_CYC(16)
`endif
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_prod(cmd_prod), .cmd_arg(cmd_arg),
      .vend_valid(vend_valid), .vend_prod(vend_prod),
      .coin_valid(coin_valid), .coin_code(coin_code), .coin_ready(coin_ready),
      .err_valid(err_valid), .err_code(err_code), .credit(credit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic send(input int op, input int prod, input int arg);
      check("cmd_ready_before_cmd", 32'(cmd_ready), 1);
      cmd_valid = 1'b1;
      cmd_op    = 3'(op);
      cmd_prod  = PROD_W'(prod);
      cmd_arg   = MONEY_W'(arg);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic coins(input int code, input int n);
      for (int i = 0; i < n; i++) send(OP_COIN, 0, code);
   endtask

   task automatic expect_err(input string tag, input int code);
      check({tag, "_err_valid"}, 32'(err_valid), 1);
      check({tag, "_err_code"}, 32'(err_code), 32'(code));
   endtask

   task automatic take_change(input int codes[$], input int stall, input int bound);
      for (int k = 0; k < codes.size(); k++) begin
         int w = 0;
         while (!coin_valid && w < bound) begin
            @(negedge clk);
            w++;
         end
         check("coin_valid", 32'(coin_valid), 1);
         check("coin_code", 32'(coin_code), 32'(codes[k]));
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_coin_code", 32'(coin_code), 32'(codes[k]));
            check("stall_cmd_ready", 32'(cmd_ready), 0);
         end
         coin_ready = 1'b1;
         @(negedge clk);
         coin_ready = 1'b0;
      end
      check("change_done_valid", 32'(coin_valid), 0);
      check("change_done_credit", 32'(credit), 0);
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_prod = '0; cmd_arg = '0; coin_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready), 0);
      check("rst_credit", 32'(credit), 0);
      check("rst_vend_valid", 32'(vend_valid), 0);
      check("rst_coin_valid", 32'(coin_valid), 0);
      check("rst_err_valid", 32'(err_valid), 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_cmd_ready", 32'(cmd_ready), 1);

      // 260 in, buy product 0 at 250, one 10 coin back
      coins(6, 5);
      coins(4, 1);
      check("credit_260", 32'(credit), 260);
      send(OP_BUY, 0, 0);
      check("buy0_vend_valid", 32'(vend_valid), 1);
      check("buy0_vend_prod", 32'(vend_prod), 0);
      check("buy0_credit", 32'(credit), 10);
      check("buy0_busy", 32'(cmd_ready), 0);
      exp_q = '{4};
      take_change(exp_q, 0, 4);
      // stock 2 -> 1 -> 0, then out of stock
      coins(6, 5);
      send(OP_BUY, 0, 0);
      check("buy0b_vend_valid", 32'(vend_valid), 1);
      @(negedge clk);
      check("buy0b_no_change", 32'(coin_valid), 0);
      coins(6, 5);
      send(OP_BUY, 0, 0);
      expect_err("stock0", 5);
      check("stock0_credit", 32'(credit), 250);
      send(OP_REFUND, 0, 0);
      exp_q = '{6, 6, 6, 6, 6};
      take_change(exp_q, 0, 4);

      // insufficient credit, then refund 30 as 20+10
      coins(5, 1);
      coins(4, 1);
      send(OP_BUY, 1, 0);
      expect_err("nocredit", 4);
      check("nocredit_credit", 32'(credit), 30);
      check("nocredit_no_vend", 32'(vend_valid), 0);
      @(negedge clk);
      check("err_pulse_drops", 32'(err_valid), 0);
      send(OP_REFUND, 0, 0);
      exp_q = '{5, 4};
      take_change(exp_q, 0, 4);

      // empty product and bad indices
      send(OP_SET_QTY, 2, 0);
      check("setqty_no_err", 32'(err_valid), 0);
      coins(6, 6);
      send(OP_BUY, 2, 0);
      expect_err("empty2", 5);
      send(OP_BUY, N_PROD, 0);
      expect_err("badprod_buy", 3);
      send(OP_SET_PRICE, 7, 5);
      expect_err("badprod_price", 3);
      check("badprod_credit", 32'(credit), 300);
      send(OP_REFUND, 0, 0);
      exp_q = '{6, 6, 6, 6, 6, 6};
      take_change(exp_q, 0, 4);

      // change of 88 with 3-cycle stall per beat
      send(OP_SET_PRICE, 3, 12);
      coins(6, 2);
      send(OP_BUY, 3, 0);
      check("buy3_vend_prod", 32'(vend_prod), 3);
      check("buy3_credit", 32'(credit), 88);
      exp_q = '{6, 5, 4, 3, 2, 1};
      take_change(exp_q, 3, 4);

      // overflow boundary at 2047
      coins(6, 40);
      coins(5, 2);
      check("credit_2040", 32'(credit), 2040);
      send(OP_COIN, 0, 6);
      expect_err("ovf50", 2);
      check("ovf50_credit", 32'(credit), 2040);
      send(OP_COIN, 0, 7);
      expect_err("coin7", 1);
      send(OP_COIN, 0, 0);
      expect_err("coin0", 1);
      coins(3, 1);
      coins(2, 1);
      check("credit_max", 32'(credit), 2047);
      check("credit_max_no_err", 32'(err_valid), 0);
      send(OP_COIN, 0, 1);
      expect_err("ovf1", 2);
      check("ovf1_credit", 32'(credit), 2047);

      // reset in the middle of change
      send(OP_REFUND, 0, 0);
      coin_ready = 1'b1;
      @(negedge clk);
      coin_ready = 1'b0;
      check("mid_change_credit", 32'(credit), 1997);
      check("mid_change_valid", 32'(coin_valid), 1);
      rst = 1'b1;
      @(negedge clk);
      check("abort_coin_valid", 32'(coin_valid), 0);
      check("abort_credit", 32'(credit), 0);
      check("abort_cmd_ready", 32'(cmd_ready), 0);
      rst = 1'b0;
      @(negedge clk);
      coins(6, 5);
      send(OP_BUY, 2, 0);
      check("dflt_qty_vend", 32'(vend_valid), 1);
      check("dflt_qty_prod", 32'(vend_prod), 2);
      check("dflt_price_credit", 32'(credit), 0);
      @(negedge clk);
      check("after_vend_idle", 32'(cmd_ready), 1);
      coins(6, 2);
      send(OP_BUY, 3, 0);
      expect_err("dflt_price3", 4);
      send(OP_REFUND, 0, 0);
      exp_q = '{6, 6};
      take_change(exp_q, 0, 4);

      // reserved op and zero-credit refund
      send(5, 0, 0);
      check("reserved_no_err", 32'(err_valid), 0);
      send(OP_REFUND, 0, 0);
      check("refund0_no_coin", 32'(coin_valid), 0);
      check("refund0_ready", 32'(cmd_ready), 1);

      // idle credit of 5
      coins(3, 1);
`ifdef VENDING_TIMEOUT_EN
      exp_q = '{3};
      take_change(exp_q, 0, 40);
`else
      repeat (40) @(negedge clk);
      check("hold_coin_valid", 32'(coin_valid), 0);
      check("hold_credit", 32'(credit), 5);
      send(OP_REFUND, 0, 0);
      exp_q = '{3};
      take_change(exp_q, 0, 4);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
